// File: rtl/cmd_decode_module.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_decode_module
//  Description : Host command frame decoder. Validates sync/cmd/len/checksum
//                and atomically loads laser, motor and accumulation settings.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_decode_module #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_out_valid,
    output logic        fifo_out_ready,
    input  logic [31:0] fifo_out_data,
    output logic        laser_enable,
    output logic [31:0] laser_freq,
    output logic        motor_enable,
    output logic        motor_direction,
    output logic [31:0] motor_time,
    output logic [31:0] motor_max_speed,
    output logic [31:0] acc_time,
    output logic [31:0] acc_threshold,
    output logic        upload_en,
    output logic        sys_acquire,
    output logic        err_upload,
    output logic [31:0] cmd_err_cnt
);

    localparam logic [15:0] c_SYNC      = 16'h1234;
    localparam logic [31:0] c_IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [4:0] {
        S_HUNT  = 5'b00001,
        S_DATA  = 5'b00010,
        S_CHECK = 5'b00100,
        S_APPLY = 5'b01000,
        S_ERROR = 5'b10000
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cmd;
    logic [1:0]  r_len;
    logic [1:0]  r_idx;
    logic [31:0] r_xor;
    logic [31:0] r_idle;
    logic [31:0] r_shadow [3];

    logic        w_accept;
    logic        w_is_head;
    logic [1:0]  w_head_len;
    logic        w_head_ok;

    // Required payload length per command; zero marks an unknown command.
    function automatic logic [1:0] f_cmd_len(input logic [7:0] cmd);
        case (cmd)
            8'h01:   f_cmd_len = 2'd2;
            8'h02:   f_cmd_len = 2'd3;
            8'h03:   f_cmd_len = 2'd2;
            8'h04:   f_cmd_len = 2'd1;
            8'h05:   f_cmd_len = 2'd1;
            default: f_cmd_len = 2'd0;
        endcase
    endfunction

    assign w_accept   = fifo_out_valid & fifo_out_ready;
    assign w_is_head  = (fifo_out_data[31:16] == c_SYNC);
    assign w_head_len = f_cmd_len(fifo_out_data[15:8]);
    assign w_head_ok  = (w_head_len != 2'd0) && (fifo_out_data[7:0] == {6'd0, w_head_len});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_HUNT;
            fifo_out_ready  <= 1'b0;
            r_cmd           <= '0;
            r_len           <= '0;
            r_idx           <= '0;
            r_xor           <= '0;
            r_idle          <= '0;
            for (int i = 0; i < 3; i++) r_shadow[i] <= '0;
            laser_enable    <= 1'b0;
            laser_freq      <= '0;
            motor_enable    <= 1'b0;
            motor_direction <= 1'b0;
            motor_time      <= '0;
            motor_max_speed <= '0;
            acc_time        <= '0;
            acc_threshold   <= '0;
            upload_en       <= 1'b0;
            sys_acquire     <= 1'b0;
            err_upload      <= 1'b0;
            cmd_err_cnt     <= '0;
        end else begin
            sys_acquire <= 1'b0;
            err_upload  <= 1'b0;
            case (r_state)
                S_HUNT: begin
                    fifo_out_ready <= 1'b1;
                    if (w_accept && w_is_head) begin
                        r_cmd  <= fifo_out_data[15:8];
                        r_len  <= w_head_len;
                        r_idx  <= '0;
                        r_xor  <= fifo_out_data;
                        r_idle <= '0;
                        if (w_head_ok) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state        <= S_ERROR;
                            fifo_out_ready <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_shadow[r_idx] <= fifo_out_data;
                        r_xor           <= r_xor ^ fifo_out_data;
                        r_idle          <= '0;
                        if (r_idx == r_len - 2'd1) r_state <= S_CHECK;
                        else                       r_idx   <= r_idx + 2'd1;
                    end else if (r_idle == c_IDLE_LAST) begin
                        r_state        <= S_ERROR;
                        fifo_out_ready <= 1'b0;
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_idle         <= '0;
                        fifo_out_ready <= 1'b0;
                        r_state        <= (fifo_out_data == r_xor) ? S_APPLY : S_ERROR;
                    end else if (r_idle == c_IDLE_LAST) begin
                        r_state        <= S_ERROR;
                        fifo_out_ready <= 1'b0;
                    end else begin
                        r_idle <= r_idle + 32'd1;
                    end
                end
                S_APPLY: begin
                    // All fields of one command load on the same edge.
                    case (r_cmd)
                        8'h01: begin
                            laser_enable <= r_shadow[0][0];
                            laser_freq   <= r_shadow[1];
                        end
                        8'h02: begin
                            motor_enable    <= r_shadow[0][0];
                            motor_direction <= r_shadow[0][1];
                            motor_time      <= r_shadow[1];
                            motor_max_speed <= r_shadow[2];
                        end
                        8'h03: begin
                            acc_time      <= r_shadow[0];
                            acc_threshold <= r_shadow[1];
                        end
                        8'h04:   upload_en   <= r_shadow[0][0];
                        8'h05:   sys_acquire <= 1'b1;
                        default: ;
                    endcase
                    r_state        <= S_HUNT;
                    fifo_out_ready <= 1'b1;
                end
                S_ERROR: begin
                    err_upload <= 1'b1;
                    if (cmd_err_cnt != 32'hFFFF_FFFF) cmd_err_cnt <= cmd_err_cnt + 32'd1;
                    r_state        <= S_HUNT;
                    fifo_out_ready <= 1'b1;
                end
                default: begin
                    r_state        <= S_HUNT;
                    fifo_out_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_decode_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_decode_module
//  Description : Self-checking bench for cmd_decode_module, frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_decode_module;

    logic        clk;
    logic        rst_n;
    logic        fifo_out_valid;
    logic        fifo_out_ready;
    logic [31:0] fifo_out_data;
    logic        laser_enable;
    logic [31:0] laser_freq;
    logic        motor_enable;
    logic        motor_direction;
    logic [31:0] motor_time;
    logic [31:0] motor_max_speed;
    logic [31:0] acc_time;
    logic [31:0] acc_threshold;
    logic        upload_en;
    logic        sys_acquire;
    logic        err_upload;
    logic [31:0] cmd_err_cnt;

    cmd_decode_module #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_out_valid  (fifo_out_valid),
        .fifo_out_ready  (fifo_out_ready),
        .fifo_out_data   (fifo_out_data),
        .laser_enable    (laser_enable),
        .laser_freq      (laser_freq),
        .motor_enable    (motor_enable),
        .motor_direction (motor_direction),
        .motor_time      (motor_time),
        .motor_max_speed (motor_max_speed),
        .acc_time        (acc_time),
        .acc_threshold   (acc_threshold),
        .upload_en       (upload_en),
        .sys_acquire     (sys_acquire),
        .err_upload      (err_upload),
        .cmd_err_cnt     (cmd_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitors count high cycles, so a stretched pulse shows up too.
    int mon_err = 0;
    int mon_sys = 0;
    always @(negedge clk) begin
        if (err_upload)  mon_err++;
        if (sys_acquire) mon_sys++;
    end

    // Reference state
    logic        m_laser_en, m_motor_en, m_motor_dir, m_upload_en;
    logic [31:0] m_laser_freq, m_motor_time, m_motor_speed, m_acc_time, m_acc_thr, m_err_cnt;
    int          exp_err = 0;
    int          exp_sys = 0;
    logic [31:0] frame_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_laser_en = 0; m_motor_en = 0; m_motor_dir = 0; m_upload_en = 0;
        m_laser_freq = 0; m_motor_time = 0; m_motor_speed = 0;
        m_acc_time = 0; m_acc_thr = 0; m_err_cnt = 0;
    endtask

    function automatic int cmd_len(input logic [7:0] cmd);
        case (cmd)
            8'h01: return 2;
            8'h02: return 3;
            8'h03: return 2;
            8'h04: return 1;
            8'h05: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_error();
        exp_err++;
        if (m_err_cnt != 32'hFFFF_FFFF) m_err_cnt++;
    endtask

    // Interprets the whole frame in frame_q at once.
    task automatic model_frame();
        logic [31:0] head, x;
        int          len;
        head = frame_q[0];
        if (head[31:16] != 16'h1234) return;
        len = cmd_len(head[15:8]);
        if (len == 0 || int'(head[7:0]) != len) begin
            model_error();
            return;
        end
        x = 0;
        for (int i = 0; i <= len; i++) x ^= frame_q[i];
        if (frame_q[len+1] != x) begin
            model_error();
            return;
        end
        case (head[15:8])
            8'h01: begin m_laser_en = frame_q[1][0]; m_laser_freq = frame_q[2]; end
            8'h02: begin
                m_motor_en = frame_q[1][0]; m_motor_dir = frame_q[1][1];
                m_motor_time = frame_q[2]; m_motor_speed = frame_q[3];
            end
            8'h03: begin m_acc_time = frame_q[1]; m_acc_thr = frame_q[2]; end
            8'h04: m_upload_en = frame_q[1][0];
            8'h05: exp_sys++;
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".laser_en"},  32'(laser_enable),    32'(m_laser_en));
        check_val({tag, ".laser_freq"}, laser_freq,          m_laser_freq);
        check_val({tag, ".motor_en"},  32'(motor_enable),    32'(m_motor_en));
        check_val({tag, ".motor_dir"}, 32'(motor_direction), 32'(m_motor_dir));
        check_val({tag, ".motor_time"}, motor_time,          m_motor_time);
        check_val({tag, ".motor_spd"}, motor_max_speed,      m_motor_speed);
        check_val({tag, ".acc_time"},  acc_time,             m_acc_time);
        check_val({tag, ".acc_thr"},   acc_threshold,        m_acc_thr);
        check_val({tag, ".upload_en"}, 32'(upload_en),       32'(m_upload_en));
        check_val({tag, ".err_cnt"},   cmd_err_cnt,          m_err_cnt);
        check_val({tag, ".err_pulses"}, 32'(mon_err),        32'(exp_err));
        check_val({tag, ".sys_pulses"}, 32'(mon_sys),        32'(exp_sys));
    endtask

    // Returns 1 ns after the edge that consumed the word.
    task automatic send_word(input logic [31:0] w);
        int t;
        t = 0;
        @(negedge clk);
        fifo_out_valid = 1'b1;
        fifo_out_data  = w;
        while (!fifo_out_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check_val("ready_wait", 32'(fifo_out_ready), 32'd1);
        @(posedge clk);
        #1 fifo_out_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag);
        for (int i = 0; i < frame_q.size(); i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(frame_q[i]);
        end
        repeat (4) @(negedge clk);
        model_frame();
        check_outputs(tag);
    endtask

    function automatic logic [31:0] xor_q();
        logic [31:0] x;
        x = 0;
        foreach (frame_q[i]) x ^= frame_q[i];
        return x;
    endfunction

    task automatic gen_random_frame();
        int          kind, len;
        logic [7:0]  cmd;
        logic [31:0] w;
        frame_q.delete();
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            w = $urandom;
            if (w[31:16] == 16'h1234) w[31:16] = 16'hBEEF;
            frame_q.push_back(w);
        end else if (kind == 1) begin
            cmd = 8'($urandom_range(6, 255));
            frame_q.push_back({16'h1234, cmd, 8'($urandom_range(0, 3))});
        end else if (kind == 2) begin
            cmd = 8'($urandom_range(1, 5));
            len = $urandom_range(0, 255);
            if (len == cmd_len(cmd)) len = len + 4;
            frame_q.push_back({16'h1234, cmd, 8'(len)});
        end else begin
            cmd = 8'($urandom_range(1, 5));
            len = cmd_len(cmd);
            frame_q.push_back({16'h1234, cmd, 8'(len)});
            for (int i = 0; i < len; i++) frame_q.push_back($urandom);
            w = xor_q();
            if ($urandom_range(0, 4) == 0) w ^= (32'd1 << $urandom_range(0, 31));
            frame_q.push_back(w);
        end
    endtask

    initial begin
        int e0;
        fifo_out_valid = 1'b0;
        fifo_out_data  = '0;
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check_val("reset.ready", 32'(fifo_out_ready), 32'd0);
        check_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Laser frame
        frame_q = '{32'h12340102, 32'h00000001, 32'h000003E8, 32'h123402EB};
        run_frame("laser");
        check_val("laser.freq_1000", laser_freq, 32'd1000);

        // System-info request pulse timing
        frame_q = '{32'h12340501, 32'h00000000, 32'h12340501};
        foreach (frame_q[i]) send_word(frame_q[i]);
        check_val("sys.edgeN", 32'(sys_acquire), 32'd0);
        @(posedge clk); #1;
        check_val("sys.edgeN1", 32'(sys_acquire), 32'd1);
        @(posedge clk); #1;
        check_val("sys.edgeN2", 32'(sys_acquire), 32'd0);
        repeat (3) @(negedge clk);
        model_frame();
        check_outputs("sys");

        // Junk before a valid frame, then unknown command
        frame_q = '{32'hDEADBEEF};
        run_frame("junk");
        check_val("junk.err_cnt0", cmd_err_cnt, 32'd0);
        frame_q = '{32'h12340102, 32'h00000000, 32'h00000005, 32'h12340107};
        run_frame("laser2");
        frame_q = '{32'h12340903};
        run_frame("unknown");

        // Bad checksum leaves upload_en untouched, good one sets it
        frame_q = '{32'h12340401, 32'h00000001, 32'h12340401};
        run_frame("badsum");
        check_val("badsum.upload_en", 32'(upload_en), 32'd0);
        frame_q = '{32'h12340401, 32'h00000001, 32'h12340400};
        run_frame("goodsum");
        check_val("goodsum.upload_en", 32'(upload_en), 32'd1);

        // Inter-word timeout
        e0 = mon_err;
        send_word(32'h12340302);
        send_word(32'h00000005);
        repeat (10) @(negedge clk);
        check_val("timeout.not_early", 32'(mon_err), 32'(e0));
        for (int t = 0; t < 30 && mon_err == e0; t++) @(negedge clk);
        check_val("timeout.fired", 32'(mon_err), 32'(e0 + 1));
        repeat (3) @(negedge clk);
        model_error();
        check_outputs("timeout");

        // Reset mid-frame
        send_word(32'h12340102);
        send_word(32'h00000001);
        @(negedge clk) rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rstmid.ready", 32'(fifo_out_ready), 32'd0);
        check_outputs("rstmid");
        @(negedge clk) rst_n = 1'b1;
        frame_q = '{32'h12340302, 32'h00000007, 32'h00000009};
        frame_q.push_back(xor_q());
        run_frame("after_rst");

        // Randomised frames
        for (int n = 0; n < 80; n++) begin
            gen_random_frame();
            run_frame($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
